// File: rtl/conv_output_writer.sv
`default_nettype none
// ============================================================================
// Module   : conv_output_writer
// Brief    : Output-side SRAM writer for the convolution datapath. Packs the
//            1-bit-per-pixel result stream into one word per output row (MSB
//            first) and writes an optional dimension header, the row words
//            and an end-of-stream marker to the output SRAM.
//            Build option: define OUT_HDR_EN to emit the two header words
//            (row count, column count) ahead of the row words.
// Revision : 1.0 - initial release
// ============================================================================
module conv_output_writer #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] END_WORD = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              img_start,
  input  logic [4:0]        out_nrows,
  input  logic [4:0]        out_ncols,
  input  logic              pix_valid,
  input  logic              pix_data,
  output logic              pix_ready,
  input  logic              stream_end,
  input  logic              addr_clear,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              wr_busy,
  output logic              img_done
);

  // State encoding
  localparam logic [2:0] c_st_idle    = 3'd0;
`ifdef OUT_HDR_EN
  localparam logic [2:0] c_st_hdr_r   = 3'd1;
  localparam logic [2:0] c_st_hdr_c   = 3'd2;
`endif
  localparam logic [2:0] c_st_collect = 3'd3;
  localparam logic [2:0] c_st_term    = 3'd4;

  // First state after an accepted img_start
`ifdef OUT_HDR_EN
  localparam logic [2:0] c_st_first   = c_st_hdr_r;
`else
  localparam logic [2:0] c_st_first   = c_st_collect;
`endif

  // Column 0 lands in the word MSB
  localparam logic [DATA_W-1:0] c_msb_bit = {1'b1, {(DATA_W-1){1'b0}}};

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [4:0]        r_nrows;
  logic [4:0]        r_ncols;
  logic [4:0]        r_row;
  logic [4:0]        r_col;
  logic [DATA_W-1:0] r_shift;
  logic              r_end_pend;

  logic              w_start;
  logic              w_accept;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_row_done;
  logic              w_img_last;
  logic              w_busy_state;
  logic [DATA_W-1:0] w_bit_mask;
  logic [DATA_W-1:0] w_row_word;

  logic              w_we_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_done_nxt;
  logic              w_ready_nxt;
  logic              w_busy_nxt;

  // stream_end has priority over img_start in IDLE, so a coincident start is dropped
  assign w_start      = (r_state == c_st_idle) && img_start && !stream_end;
  assign w_accept     = pix_valid && pix_ready;
  assign w_last_col   = (r_col == (r_ncols - 5'd1));
  assign w_last_row   = (r_row == (r_nrows - 5'd1));
  assign w_row_done   = (r_state == c_st_collect) && w_accept && w_last_col;
  assign w_img_last   = w_row_done && w_last_row;
  assign w_busy_state = (r_state != c_st_idle) && (r_state != c_st_term);
  assign w_bit_mask   = c_msb_bit >> r_col;
  assign w_row_word   = r_shift | (pix_data ? w_bit_mask : {DATA_W{1'b0}});

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; TERM issues its END_WORD write on the way back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (stream_end) begin
          w_state_nxt = c_st_term;
        end else if (img_start) begin
          w_state_nxt = c_st_first;
        end
      end
`ifdef OUT_HDR_EN
      c_st_hdr_r:   w_state_nxt = c_st_hdr_c;
      c_st_hdr_c:   w_state_nxt = c_st_collect;
`endif
      c_st_collect: begin
        if (w_img_last) begin
          w_state_nxt = (r_end_pend || stream_end) ? c_st_term : c_st_idle;
        end
      end
      c_st_term:    w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  // Next values of the registered SRAM write port and img_done
  always_comb begin
    w_we_nxt   = 1'b0;
    w_data_nxt = dut_sram_write_data;
    w_done_nxt = 1'b0;
    case (r_state)
      c_st_idle: begin
`ifdef OUT_HDR_EN
        if (w_start) begin
          w_we_nxt   = 1'b1;
          w_data_nxt = {{(DATA_W-5){1'b0}}, out_nrows};
        end
`endif
      end
`ifdef OUT_HDR_EN
      c_st_hdr_r: begin
        w_we_nxt   = 1'b1;
        w_data_nxt = {{(DATA_W-5){1'b0}}, r_ncols};
      end
`endif
      c_st_collect: begin
        if (w_row_done) begin
          w_we_nxt   = 1'b1;
          w_data_nxt = w_row_word;
          w_done_nxt = w_last_row;
        end
      end
      c_st_term: begin
        w_we_nxt   = 1'b1;
        w_data_nxt = END_WORD;
      end
      default: ;
    endcase
  end

  // busy stays up through the img_done cycle and drops afterwards
  assign w_ready_nxt = (w_state_nxt == c_st_collect);
  assign w_busy_nxt  = ((w_state_nxt != c_st_idle) && (w_state_nxt != c_st_term)) || w_done_nxt;

  // Registered outputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dut_sram_write_enable <= 1'b0;
      dut_sram_write_data   <= {DATA_W{1'b0}};
      img_done              <= 1'b0;
      pix_ready             <= 1'b0;
      wr_busy               <= 1'b0;
    end else begin
      dut_sram_write_enable <= w_we_nxt;
      dut_sram_write_data   <= w_data_nxt;
      img_done              <= w_done_nxt;
      pix_ready             <= w_ready_nxt;
      wr_busy               <= w_busy_nxt;
    end
  end

  // Dimension latch, row/column counters and row shift register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_nrows <= 5'd0;
      r_ncols <= 5'd0;
      r_row   <= 5'd0;
      r_col   <= 5'd0;
      r_shift <= {DATA_W{1'b0}};
    end else if (w_start) begin
      r_nrows <= out_nrows;
      r_ncols <= out_ncols;
      r_row   <= 5'd0;
      r_col   <= 5'd0;
      r_shift <= {DATA_W{1'b0}};
    end else if (w_row_done) begin
      r_col   <= 5'd0;
      r_shift <= {DATA_W{1'b0}};
      r_row   <= r_row + 5'd1;
    end else if ((r_state == c_st_collect) && w_accept) begin
      r_col   <= r_col + 5'd1;
      r_shift <= w_row_word;
    end
  end

  // End request raised while an image is in flight is held until the last row
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_end_pend <= 1'b0;
    end else if (w_state_nxt == c_st_term) begin
      r_end_pend <= 1'b0;
    end else if (w_busy_state && stream_end) begin
      r_end_pend <= 1'b1;
    end
  end

  // Write address: post-increments after each write, persists across images
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dut_sram_write_address <= {ADDR_W{1'b0}};
    end else if ((r_state == c_st_idle) && addr_clear) begin
      dut_sram_write_address <= {ADDR_W{1'b0}};
    end else if (dut_sram_write_enable) begin
      dut_sram_write_address <= dut_sram_write_address + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_output_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_output_writer
// Brief    : Self-checking bench for conv_output_writer. Expected SRAM writes
//            are built from image dimensions and pixel bits as an ordered
//            list of (address, data, last-row) entries; one monitor compares
//            every DUT write and timing relationship against it.
//            Header expectations follow the OUT_HDR_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_output_writer;

  localparam logic [15:0] END_W = 16'h00FF;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        img_start;
  logic [4:0]  out_nrows;
  logic [4:0]  out_ncols;
  logic        pix_valid;
  logic        pix_data;
  logic        pix_ready;
  logic        stream_end;
  logic        addr_clear;
  logic        we;
  logic [11:0] waddr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;

  conv_output_writer #(.ADDR_W(12), .DATA_W(16), .END_WORD(16'h00FF)) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .img_start              (img_start),
    .out_nrows              (out_nrows),
    .out_ncols              (out_ncols),
    .pix_valid              (pix_valid),
    .pix_data               (pix_data),
    .pix_ready              (pix_ready),
    .stream_end             (stream_end),
    .addr_clear             (addr_clear),
    .dut_sram_write_enable  (we),
    .dut_sram_write_address (waddr),
    .dut_sram_write_data    (wdata),
    .wr_busy                (busy),
    .img_done               (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [15:0] d;
    bit          last;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         seen_q[$];
  wr_t         mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] m_addr = 12'd0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          rel = 0;
  bit          t_armed = 1'b0;
  int          acc = 0;
  int          cur_nc = 1;
  int          ready_cnt = 0;
  bit          row_due = 1'b0;
  bit          end_due = 1'b0;
  bit          end_after_img = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every write checked against the expected list, plus timing
  always @(negedge clk) begin
    if (reset_b) begin
      if (t_armed) begin
        rel = cyc - start_cyc;
`ifdef OUT_HDR_EN
        if (rel == 1) begin
          chk("hdr_r_we", 32'(we), 32'd1);
          chk("busy_start", 32'(busy), 32'd1);
          chk("ready_in_hdr_r", 32'(pix_ready), 32'd0);
        end
        if (rel == 2) begin
          chk("hdr_c_we", 32'(we), 32'd1);
          chk("ready_in_hdr_c", 32'(pix_ready), 32'd0);
        end
        if (rel == 3) begin
          chk("ready_first", 32'(pix_ready), 32'd1);
          t_armed = 1'b0;
        end
`else
        if (rel == 1) begin
          chk("busy_start", 32'(busy), 32'd1);
          chk("ready_first", 32'(pix_ready), 32'd1);
          t_armed = 1'b0;
        end
`endif
      end
      if (we) begin
        mon_e.a = waddr; mon_e.d = wdata; mon_e.last = done;
        seen_q.push_back(mon_e);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: got %h @%h, required no write", wdata, waddr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(waddr), 32'(mon_e.a));
          chk("wr_data", 32'(wdata), 32'(mon_e.d));
          chk("img_done", 32'(done), 32'(mon_e.last));
        end
      end else begin
        chk("img_done_no_write", 32'(done), 32'd0);
      end
      if (row_due) chk("row_latency", 32'(we), 32'd1);
      row_due = 1'b0;
      if (pix_valid && pix_ready) begin
        acc++;
        if (acc % cur_nc == 0) row_due = 1'b1;
      end
      if (pix_ready) ready_cnt++;
      if (end_due) begin
        chk("end_latency_we", 32'(we), 32'd1);
        chk("end_latency_data", 32'(wdata), 32'(END_W));
        end_due = 1'b0;
      end
      if (we && done && end_after_img) begin
        end_due = 1'b1;
        end_after_img = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [15:0] d, input bit last);
    wr_t e;
    e.a = m_addr; e.d = d; e.last = last;
    exp_q.push_back(e);
    m_addr = m_addr + 12'd1;
  endtask

  // bits[k] is pixel k = row*nc + col; stops early after stop_after accepts
  task automatic run_image(input int nr, input int nc, input logic [255:0] bits,
                           input bit gaps, input bit noise, input int end_at,
                           input int stop_after);
    logic [15:0] w;
    int          k;
    int          tmo;
    bit          pend;
    bit          acc_now;
`ifdef OUT_HDR_EN
    push_wr(16'(nr), 1'b0);
    push_wr(16'(nc), 1'b0);
`endif
    for (int r = 0; r < nr; r++) begin
      w = 16'd0;
      for (int c = 0; c < nc; c++) if (bits[r*nc + c]) w = w | (16'h8000 >> c);
      push_wr(w, r == nr - 1);
    end
    acc = 0; cur_nc = nc; ready_cnt = 0;
    out_nrows = 5'(nr); out_ncols = 5'(nc); img_start = 1'b1;
    start_cyc = cyc; t_armed = 1'b1;
    tick();
    img_start = 1'b0;
    out_nrows = 5'($urandom_range(1, 16)); out_ncols = 5'($urandom_range(1, 16));
    k = 0; tmo = 0; pend = 1'b0;
    while (k < nr*nc && k < stop_after) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0; pix_data = 1'($urandom_range(0, 1));
      end else begin
        pix_valid = 1'b1; pix_data = bits[k];
      end
      if (noise && $urandom_range(0, 7) == 0) img_start = 1'b1;
      if (!pend && ((k == end_at) || (noise && $urandom_range(0, 15) == 0))) begin
        stream_end = 1'b1; pend = 1'b1;
        push_wr(END_W, 1'b0);
        end_after_img = 1'b1;
      end
      @(negedge clk);
      acc_now = pix_valid && pix_ready;
      tick();
      img_start = 1'b0; stream_end = 1'b0;
      if (acc_now) k++;
      tmo++;
      if (tmo > 2000) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout: got %0d accepts, required %0d", k, nr*nc);
        break;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin tick(); t++; end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tick(); tick();
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic clear_addr();
    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    m_addr = 12'd0;
    @(negedge clk);
    chk("addr_clear", 32'(waddr), 32'd0);
  endtask

  task automatic chk_seen(input int i, input logic [11:0] a, input logic [15:0] d);
    if (i < seen_q.size()) begin
      chk($sformatf("seen%0d_addr", i), 32'(seen_q[i].a), 32'(a));
      chk($sformatf("seen%0d_data", i), 32'(seen_q[i].d), 32'(d));
    end else begin
      n_vec++; n_err++;
      $display("FAIL seen%0d: got no write, required %h @%h", i, d, a);
    end
  endtask

  function automatic logic [255:0] rand_bits();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(waddr), 32'd0);
    chk("rst_data", 32'(wdata), 32'd0);
    chk("rst_ready", 32'(pix_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
  endtask

  initial begin
    logic [255:0] b;
    reset_b = 1'b0; img_start = 1'b0; out_nrows = 5'd0; out_ncols = 5'd0;
    pix_valid = 1'b0; pix_data = 1'b0; stream_end = 1'b0; addr_clear = 1'b0;
    tick(); tick(); tick();
    chk_reset_outputs();
    reset_b = 1'b1;
    tick();

    // rows 1011 / 0110 / 1111 from address 0
    seen_q.delete();
    b = '0; b[11:0] = 12'hF6D;
    run_image(3, 4, b, 1'b0, 1'b0, -1, 1000);
    drain();
`ifdef OUT_HDR_EN
    chk_seen(0, 12'h000, 16'h0003);
    chk_seen(1, 12'h001, 16'h0004);
    chk_seen(2, 12'h002, 16'hB000);
    chk_seen(3, 12'h003, 16'h6000);
    chk_seen(4, 12'h004, 16'hF000);
`else
    chk_seen(0, 12'h000, 16'hB000);
    chk_seen(1, 12'h001, 16'h6000);
    chk_seen(2, 12'h002, 16'hF000);
`endif

    // full-width all-ones row, valid held
    seen_q.delete();
    b = '1;
    run_image(1, 16, b, 1'b0, 1'b0, -1, 1000);
    drain();
    chk("ready_cycles_16col", 32'(ready_cnt), 32'd16);
    chk_seen(seen_q.size() - 1, waddr - 12'd1, 16'hFFFF);

    // single column: one write per cycle
    run_image(16, 1, rand_bits(), 1'b0, 1'b0, -1, 1000);
    drain();
    chk("ready_cycles_1col", 32'(ready_cnt), 32'd16);

    // stream_end mid-image
    seen_q.delete();
    run_image(2, 2, rand_bits(), 1'b0, 1'b0, 1, 1000);
    drain();
    chk_seen(seen_q.size() - 1, waddr - 12'd1, END_W);

    // img_start and stream_end together in IDLE: only END_WORD
    out_nrows = 5'd2; out_ncols = 5'd2; img_start = 1'b1; stream_end = 1'b1;
    push_wr(END_W, 1'b0);
    tick();
    img_start = 1'b0; stream_end = 1'b0;
    drain();

    // walk the address up to 0xFFE with END_WORD writes, then wrap
    clear_addr();
    for (int i = 0; i < 4094; i++) begin
      stream_end = 1'b1; push_wr(END_W, 1'b0);
      tick();
      stream_end = 1'b0;
      tick();
    end
    drain();
    chk("addr_preset", 32'(waddr), 32'h0FFE);
    seen_q.delete();
    run_image(3, 2, rand_bits(), 1'b1, 1'b0, -1, 1000);
    drain();
    chk_seen(0, 12'hFFE, seen_q.size() > 0 ? seen_q[0].d : 16'h0);
    chk_seen(2, 12'h000, seen_q.size() > 2 ? seen_q[2].d : 16'h0);
`ifdef OUT_HDR_EN
    chk("addr_after_wrap", 32'(waddr), 32'h003);
`else
    chk("addr_after_wrap", 32'(waddr), 32'h001);
`endif
    clear_addr();

    // reset mid-row aborts the image
    run_image(4, 8, rand_bits(), 1'b1, 1'b0, -1, 13);
    reset_b = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete(); m_addr = 12'd0; row_due = 1'b0; end_due = 1'b0;
    end_after_img = 1'b0; t_armed = 1'b0; acc = 0;
    tick(); tick();
    reset_b = 1'b1;
    tick();
    run_image(2, 3, rand_bits(), 1'b1, 1'b1, -1, 1000);
    drain();

    // randomized images with gaps, ignored starts and end requests
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 5) == 0) clear_addr();
      if ($urandom_range(0, 5) == 0) begin
        stream_end = 1'b1; push_wr(END_W, 1'b0);
        tick();
        stream_end = 1'b0;
        drain();
      end
      run_image($urandom_range(1, 16), $urandom_range(1, 16), rand_bits(),
                1'b1, 1'b1, -1, 1000);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/conv_output_writer.md
# conv_output_writer

Output-side SRAM writer for the convolution datapath: it is the write counterpart of the input/weight read sequencing in the controller. It accepts the 1-bit-per-pixel convolution result stream from the datapath and packs each output row into one 16-bit word, MSB first. It writes an optional dimension header, the row words, and the 0x00FF end-of-stream marker to the output SRAM through the dut_sram_write_* port.

## Interface
- ADDR_W, 12, output SRAM address width
- DATA_W, 16, output SRAM word width; also the maximum output columns
- END_WORD, 16'h00FF, end-of-stream marker
- clk  in  1  clock
- reset_b  in  1  reset, asynchronous, active-low
- img_start  in  1  one-cycle pulse; captures out_nrows/out_ncols and starts an image
- out_nrows  in  5  output rows for this image, legal range 1..16
- out_ncols  in  5  output columns for this image, legal range 1..16
- pix_valid  in  1  result bit valid
- pix_data  in  1  result bit
- pix_ready  out  1  writer accepts a bit this cycle
- stream_end  in  1  one-cycle pulse; requests the END_WORD write
- addr_clear  in  1  sets the write address to 0; honoured only in IDLE
- dut_sram_write_enable  out  1  write strobe
- dut_sram_write_address  out  12  write address
- dut_sram_write_data  out  16  write data
- wr_busy  out  1  high from img_start acceptance until img_done
- img_done  out  1  one-cycle pulse in the cycle the last row word is written

## Operation
- States: IDLE, HDR_R, HDR_C, COLLECT, TERM.
- IDLE -> HDR_R on img_start. The cycle after acceptance, nrows and ncols are latched and the row and column counters are cleared.
- HDR_R writes {11'b0, nrows}, then -> HDR_C.
- HDR_C writes {11'b0, ncols}, then -> COLLECT.
- COLLECT:
  - pix_ready = 1. A bit is accepted when pix_valid & pix_ready.
  - The bit at column c goes to bit 15-c of the row shift register. Unused LSBs are 0.
  - After the accept with c = ncols-1: the row word is written next cycle, the column counter resets, the shift register clears and the row counter increments.
- After the word for row nrows-1 is written, assert img_done and go to IDLE, unless an end request is pending (see TERM).
- TERM writes END_WORD, then -> IDLE.
- End request:
  - stream_end in IDLE -> TERM directly.
  - stream_end while busy is latched as pending. The final row write then goes to TERM instead of IDLE.
- img_start while not IDLE is ignored.
- Concurrent pulses in IDLE: if img_start and stream_end arrive in the same IDLE cycle, stream_end is serviced first (TERM) and img_start is dropped.
- Address:
  - Increments by 1 after every write and wraps 12'hFFF -> 12'h000.
  - It is not reset between images; only addr_clear in IDLE or reset_b clears it.
- pix_ready is 0 in every state except COLLECT. Bits offered outside COLLECT are not consumed.

## Timing
- All outputs are registered. Reset values: dut_sram_write_enable 0, dut_sram_write_address 0, dut_sram_write_data 0, pix_ready 0, wr_busy 0, img_done 0. State resets to IDLE; counters, shift register and end-pending flag reset to 0.
- img_start at cycle N:
  - header write enables at N+1 (HDR_R) and N+2 (HDR_C);
  - pix_ready first high at N+3.
- Accept of the last bit of a row at cycle M -> write enable at M+1.
- With ncols = 1, one write per cycle is sustained with no stall.
- img_done coincides with the write enable of the final row word.
- A pending END_WORD write follows one cycle after the final row write.
- Reset asserted mid-image aborts immediately: no further writes, and the partial row is discarded.

## Configuration
- OUT_HDR_EN defined: the two header words are written; HDR_R and HDR_C exist as described.
- OUT_HDR_EN undefined:
  - header states are removed and img_start moves IDLE -> COLLECT directly;
  - pix_ready is first high at N+1;
  - SRAM holds only row words plus END_WORD.

## Test plan
- nrows=3, ncols=4, bits 1011/0110/1111, address 0 -> writes @0=0x0003, @1=0x0004, @2=0xB000, @3=0x6000, @4=0xF000; img_done with the @4 write.
- ncols=16, nrows=1, all-ones with pix_valid held high -> row write 0xFFFF one cycle after the 16th accept; pix_ready high for exactly 16 cycles.
- stream_end mid-image (nrows=2, ncols=2) -> rows written, then END_WORD 0x00FF at the next address one cycle after img_done.
- Address preset near wrap (12'hFFE), header enabled -> writes land at 0xFFE, 0xFFF, 0x000; addr_clear then resets to 0.
- reset_b low mid-COLLECT -> all outputs 0 within the same cycle; the next img_start behaves as a fresh image.
- img_start during busy and pix_valid with pix_ready low -> ignored; no extra writes; bit count unaffected.
